// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the MIPS-subset datapath.
// Ports: clk, reset (async, high), opcode/funct from IR, zero flag,
//   mem_ready handshake; datapath enables, mux selects, ALU_Op,
//   instr_done and illegal status pulses.
module mc_ctrl #(
  parameter bit MEM_HS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Ext_Op,
  output logic       ALUSrc,
  output logic [2:0] ALU_Op,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  state_t state, state_n;

  logic r_type;
  logic is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal;
  logic to_exec, mem_go;

  assign r_type  = (opcode == 6'h00);
  assign is_addu = r_type && (funct == 6'h21);
  assign is_subu = r_type && (funct == 6'h23);
  assign is_jr   = r_type && (funct == 6'h08);
  assign is_nop  = r_type && (funct == 6'h00);
  assign is_ori  = (opcode == 6'h0d);
  assign is_lui  = (opcode == 6'h0f);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2b);
  assign is_beq  = (opcode == 6'h04);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);

  assign to_exec = is_addu | is_subu | is_ori | is_lui
                 | is_lw | is_sw | is_beq;

  // Without the handshake the access is assumed to finish in one cycle.
  assign mem_go = !MEM_HS || mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    PCWrite    = 1'b0;
    PCSrc      = 2'b00;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Ext_Op     = 1'b0;
    ALUSrc     = 1'b0;
    ALU_Op     = 3'b000;
    instr_done = 1'b0;
    illegal    = 1'b0;

    unique case (state)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        state_n = DECODE;
      end

      DECODE: begin
        state_n = FETCH;
        unique case (1'b1)
          is_j, is_jal: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b10;
            instr_done = 1'b1;
            // Link register gets PC+4, already latched in FETCH.
            if (is_jal) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end
          is_jr: begin
            PCWrite    = 1'b1;
            PCSrc      = 2'b11;
            instr_done = 1'b1;
          end
          is_nop: instr_done = 1'b1;
          to_exec: state_n = EXEC;
          default: begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end

      EXEC: begin
        state_n = FETCH;
        unique case (1'b1)
          is_addu: state_n = WB;
          is_subu: begin
            ALU_Op  = 3'b001;
            state_n = WB;
          end
          is_ori: begin
            ALUSrc  = 1'b1;
            ALU_Op  = 3'b010;
            state_n = WB;
          end
          is_lui: begin
            ALUSrc  = 1'b1;
            ALU_Op  = 3'b011;
            state_n = WB;
          end
          is_lw, is_sw: begin
            Ext_Op  = 1'b1;
            ALUSrc  = 1'b1;
            state_n = MEM;
          end
          is_beq: begin
            Ext_Op     = 1'b1;
            ALU_Op     = 3'b001;
            PCSrc      = 2'b01;
            PCWrite    = zero;
            instr_done = 1'b1;
          end
          default: state_n = FETCH;
        endcase
      end

      MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (mem_go) begin
          if (is_lw) begin
            state_n = WB;
          end else begin
            state_n    = FETCH;
            instr_done = 1'b1;
          end
        end
      end

      WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        RegDst     = r_type ? 2'b01 : 2'b00;
        MemtoReg   = is_lw ? 2'b01 : 2'b00;
        state_n    = FETCH;
      end

      default: state_n = FETCH;
    endcase

    // Outputs are forced quiet while reset is held.
    if (reset) begin
      PCWrite    = 1'b0;
      PCSrc      = 2'b00;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 2'b00;
      MemtoReg   = 2'b00;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      Ext_Op     = 1'b0;
      ALUSrc     = 1'b0;
      ALU_Op     = 3'b000;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: random instruction stream for mc_ctrl, both MEM_HS modes,
// checked per cycle against a per-instruction cycle table.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcsrc;
    logic       irw;
    logic       regw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       mrd;
    logic       mwr;
    logic       ext;
    logic       alusrc;
    logic [2:0] aluop;
    logic       done;
    logic       ill;
  } ctl_t;

  typedef enum int {
    K_ADDU, K_SUBU, K_JR, K_NOP, K_ORI, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL
  } kind_t;

  typedef enum int { S_F, S_D, S_E, S_M, S_W } step_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  wire [17:0] va, vb;

  int checks = 0;
  int errors = 0;
  bit sel;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_HS(1'b1)) dut_a (
    .clk(clk), .reset(rst_a),
    .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(va[17]), .PCSrc(va[16:15]),
    .IRWrite(va[14]), .RegWrite(va[13]),
    .RegDst(va[12:11]), .MemtoReg(va[10:9]),
    .MemRead(va[8]), .MemWrite(va[7]),
    .Ext_Op(va[6]), .ALUSrc(va[5]),
    .ALU_Op(va[4:2]), .instr_done(va[1]),
    .illegal(va[0])
  );

  mc_ctrl #(.MEM_HS(1'b0)) dut_b (
    .clk(clk), .reset(rst_b),
    .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .PCWrite(vb[17]), .PCSrc(vb[16:15]),
    .IRWrite(vb[14]), .RegWrite(vb[13]),
    .RegDst(vb[12:11]), .MemtoReg(vb[10:9]),
    .MemRead(vb[8]), .MemWrite(vb[7]),
    .Ext_Op(vb[6]), .ALUSrc(vb[5]),
    .ALU_Op(vb[4:2]), .instr_done(vb[1]),
    .illegal(vb[0])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic enc(input kind_t k,
                     output logic [5:0] op,
                     output logic [5:0] fn);
    op = 6'h00;
    fn = 6'($urandom);
    case (k)
      K_ADDU: fn = 6'h21;
      K_SUBU: fn = 6'h23;
      K_JR:   fn = 6'h08;
      K_NOP:  fn = 6'h00;
      K_ORI:  op = 6'h0d;
      K_LUI:  op = 6'h0f;
      K_LW:   op = 6'h23;
      K_SW:   op = 6'h2b;
      K_BEQ:  op = 6'h04;
      K_J:    op = 6'h02;
      K_JAL:  op = 6'h03;
      default: begin
        case ($urandom_range(0, 3))
          0: op = 6'h3f;
          1: fn = 6'h20;
          2: op = 6'h08;
          default: fn = 6'h2a;
        endcase
      end
    endcase
  endtask

  // Control word each instruction needs at each of its steps.
  function automatic ctl_t exp_ctl(kind_t k, step_t s,
                                   bit z, bit last);
    ctl_t e;
    e = '0;
    case (s)
      S_F: begin
        e.pcw = 1'b1;
        e.irw = 1'b1;
      end
      S_D: begin
        if (k == K_J || k == K_JAL) begin
          e.pcw = 1'b1;
          e.pcsrc = 2'd2;
          e.done = 1'b1;
        end
        if (k == K_JAL) begin
          e.regw = 1'b1;
          e.regdst = 2'd2;
          e.m2r = 2'd2;
        end
        if (k == K_JR) begin
          e.pcw = 1'b1;
          e.pcsrc = 2'd3;
          e.done = 1'b1;
        end
        if (k == K_NOP) e.done = 1'b1;
        if (k == K_ILL) begin
          e.ill = 1'b1;
          e.done = 1'b1;
        end
      end
      S_E: begin
        case (k)
          K_SUBU: e.aluop = 3'd1;
          K_ORI: begin
            e.alusrc = 1'b1;
            e.aluop = 3'd2;
          end
          K_LUI: begin
            e.alusrc = 1'b1;
            e.aluop = 3'd3;
          end
          K_LW, K_SW: begin
            e.ext = 1'b1;
            e.alusrc = 1'b1;
          end
          K_BEQ: begin
            e.ext = 1'b1;
            e.aluop = 3'd1;
            e.pcsrc = 2'd1;
            e.pcw = z;
            e.done = 1'b1;
          end
          default: e.aluop = 3'd0;
        endcase
      end
      S_M: begin
        e.mrd = (k == K_LW);
        e.mwr = (k == K_SW);
        e.done = (k == K_SW) && last;
      end
      default: begin
        e.regw = 1'b1;
        e.done = 1'b1;
        e.regdst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
        e.m2r = (k == K_LW) ? 2'd1 : 2'd0;
      end
    endcase
    return e;
  endfunction

  // Entered and left at posedge+1; maxs truncates the instruction.
  task automatic run_instr(input kind_t k, input int nwait,
                           input int zf, input int maxs);
    step_t steps[$];
    logic [5:0] op, fn;
    int mc;
    bit last;
    ctl_t e;
    steps.push_back(S_F);
    steps.push_back(S_D);
    if (!(k inside {K_J, K_JAL, K_JR, K_NOP, K_ILL}))
      steps.push_back(S_E);
    if (k == K_LW || k == K_SW) begin
      if (sel) for (int w = 0; w < nwait; w++) steps.push_back(S_M);
      steps.push_back(S_M);
    end
    if (k inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW})
      steps.push_back(S_W);
    enc(k, op, fn);
    mc = 0;
    for (int i = 0; i < steps.size(); i++) begin
      if (i >= maxs) break;
      opcode = op;
      funct = fn;
      zero = (zf == 2) ? 1'($urandom) : 1'(zf);
      mem_ready = 1'($urandom);
      if (steps[i] == S_M && sel) begin
        mem_ready = (mc >= nwait);
        mc++;
      end
      last = (steps[i] == S_M) &&
             (i == steps.size() - 1 || steps[i+1] != S_M);
      e = exp_ctl(k, steps[i], zero, last);
      @(negedge clk);
      chk($sformatf("%s hs%0d step%0d", k.name(), sel, i),
          32'(sel ? va : vb), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    if (sel) rst_a = 1'b1;
    else     rst_b = 1'b1;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      @(negedge clk);
      chk($sformatf("reset hs%0d c%0d", sel, i),
          32'(sel ? va : vb), 32'd0);
      @(posedge clk);
      #1;
    end
    if (sel) rst_a = 1'b0;
    else     rst_b = 1'b0;
  endtask

  initial begin
    sel = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    opcode = 6'h00;
    funct = 6'h00;
    zero = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    run_instr(K_ORI, 0, 2, 99);
    run_instr(K_LW, 0, 2, 99);
    run_instr(K_SW, 3, 2, 99);
    run_instr(K_BEQ, 0, 1, 99);
    run_instr(K_BEQ, 0, 0, 99);
    run_instr(K_JAL, 0, 2, 99);
    run_instr(K_JR, 0, 2, 99);
    run_instr(K_ILL, 0, 2, 99);
    run_instr(K_ADDU, 0, 2, 2);
    do_reset(3);
    run_instr(K_ADDU, 0, 2, 99);

    for (int n = 0; n < 150; n++)
      run_instr(kind_t'($urandom_range(0, 11)),
                $urandom_range(0, 3), 2, 99);

    rst_a = 1'b1;
    rst_b = 1'b0;
    sel = 1'b0;
    run_instr(K_SW, 3, 2, 99);
    run_instr(K_LW, 3, 2, 99);
    for (int n = 0; n < 100; n++)
      run_instr(kind_t'($urandom_range(0, 11)),
                $urandom_range(0, 3), 2, 99);
    run_instr(K_SUBU, 0, 2, 3);
    do_reset(2);
    run_instr(K_NOP, 0, 2, 99);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
